// File: rtl/amber_stim_pkg.sv
// Shared types and helpers for the Amber wishbone stimulus controller.
// Lanes are 32-bit slices of the 128-bit bus, selected by address bits [3:2].
package amber_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stim_state_e;

    localparam logic [31:0] FILL_WORD_DEFAULT = 32'hF0801003;

    function automatic logic [31:0] lane_word(input logic [127:0] bus, input logic [1:0] lane);
        return bus[{lane, 5'b0} +: 32];
    endfunction

    function automatic logic [3:0] lane_sel(input logic [15:0] sel, input logic [1:0] lane);
        return sel[{lane, 2'b0} +: 4];
    endfunction

endpackage

// File: rtl/amber_wb_stim_ctrl_if.sv
// Classic wishbone bus between the Amber core (master) and the stimulus controller (slave).
interface amber_wb_stim_ctrl_if;
    logic [31:0]  wb_adr;
    logic [15:0]  wb_sel;
    logic         wb_we;
    logic [127:0] wb_dat_w;
    logic         wb_cyc;
    logic         wb_stb;
    logic [127:0] wb_dat_r;
    logic         wb_ack;
    logic         wb_err;

    modport master (
        output wb_adr, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
        input  wb_dat_r, wb_ack, wb_err
    );

    modport slave (
        input  wb_adr, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
        output wb_dat_r, wb_ack, wb_err
    );
endinterface

// File: rtl/amber_inst_fifo.sv
// Instruction queue: DEPTH x 32 synchronous FIFO with occupancy level.
// Push while full and pop while empty are ignored; pointers wrap naturally.
module amber_inst_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/amber_wb_stim_ctrl.sv
// Wishbone slave feeding queued instructions to the Amber core, with programmable
// wait states, one-shot error insertion, store capture and a fetch counter.
module amber_wb_stim_ctrl
    import amber_stim_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] FILL_WORD = FILL_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_valid,
    input  logic [31:0]            inst_data,
    output logic                   inst_ready,
    input  logic [3:0]             wait_states,
    input  logic                   err_inject,
    amber_wb_stim_ctrl_if.slave    wb,
    output logic                   st_valid,
    output logic [31:0]            st_adr,
    output logic [31:0]            st_dat,
    output logic [3:0]             st_sel,
    output logic [15:0]            fetch_count,
    output logic [$clog2(DEPTH):0] q_level
);
    stim_state_e  state_q, state_d;
    logic [3:0]   wcnt_q, wcnt_d;
    logic [31:0]  adr_q, adr_d;
    logic         we_q, we_d;
    logic [15:0]  sel_q, sel_d;
    logic [127:0] dat_q, dat_d;
    logic         armed_q, armed_d;
    logic         pop_q, pop_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic [127:0] dat_r_q, dat_r_d;
    logic         st_valid_q, st_valid_d;
    logic [31:0]  st_adr_q, st_adr_d;
    logic [31:0]  st_dat_q, st_dat_d;
    logic [3:0]   st_sel_q, st_sel_d;
    logic [15:0]  fetch_count_q, fetch_count_d;

    logic         req, resp_go;
    logic [31:0]  cur_adr;
    logic         cur_we;
    logic [15:0]  cur_sel;
    logic [127:0] cur_dat;
    logic [1:0]   lane;
    logic [31:0]  fifo_head;
    logic         fifo_full, fifo_empty;

    amber_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inst_valid & inst_ready),
        .push_data (inst_data),
        .pop       (pop_q),
        .head      (fifo_head),
        .level     (q_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_ready = ~fifo_full;
    assign req        = wb.wb_cyc & wb.wb_stb;

    // With zero wait states the response is built straight from the bus, otherwise from the latch.
    assign cur_adr = (state_q == IDLE) ? wb.wb_adr   : adr_q;
    assign cur_we  = (state_q == IDLE) ? wb.wb_we    : we_q;
    assign cur_sel = (state_q == IDLE) ? wb.wb_sel   : sel_q;
    assign cur_dat = (state_q == IDLE) ? wb.wb_dat_w : dat_q;
    assign lane    = cur_adr[3:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        resp_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wcnt_d = wait_states;
                    if (wait_states == 4'd0) begin
                        state_d = RESP;
                        resp_go = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb.wb_stb) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'd1) begin
                    state_d = RESP;
                    wcnt_d  = 4'd0;
                    resp_go = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response outputs are computed one cycle ahead so that they leave the block registered.
    always_comb begin
        adr_d         = adr_q;
        we_d          = we_q;
        sel_d         = sel_q;
        dat_d         = dat_q;
        armed_d       = armed_q | err_inject;
        pop_d         = 1'b0;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        dat_r_d       = dat_r_q;
        st_valid_d    = 1'b0;
        st_adr_d      = st_adr_q;
        st_dat_d      = st_dat_q;
        st_sel_d      = st_sel_q;
        fetch_count_d = fetch_count_q;
        if (state_q == IDLE && req) begin
            adr_d = wb.wb_adr;
            we_d  = wb.wb_we;
            sel_d = wb.wb_sel;
            dat_d = wb.wb_dat_w;
        end
        if (resp_go) begin
            if (armed_q) begin
                err_d   = 1'b1;
                armed_d = 1'b0;
            end else begin
                ack_d = 1'b1;
                if (cur_we) begin
                    st_valid_d = 1'b1;
                    st_adr_d   = cur_adr;
                    st_dat_d   = lane_word(cur_dat, lane);
                    st_sel_d   = lane_sel(cur_sel, lane);
                end else begin
                    dat_r_d = {4{FILL_WORD}};
                    if (!fifo_empty) dat_r_d[{lane, 5'b0} +: 32] = fifo_head;
                    pop_d = ~fifo_empty;
                    if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q        <= '0;
            adr_q         <= '0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            dat_q         <= '0;
            armed_q       <= 1'b0;
            pop_q         <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            dat_r_q       <= {4{FILL_WORD}};
            st_valid_q    <= 1'b0;
            st_adr_q      <= '0;
            st_dat_q      <= '0;
            st_sel_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            wcnt_q        <= wcnt_d;
            adr_q         <= adr_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            dat_q         <= dat_d;
            armed_q       <= armed_d;
            pop_q         <= pop_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            dat_r_q       <= dat_r_d;
            st_valid_q    <= st_valid_d;
            st_adr_q      <= st_adr_d;
            st_dat_q      <= st_dat_d;
            st_sel_q      <= st_sel_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_err   = err_q;
    assign wb.wb_dat_r = dat_r_q;
    assign st_valid    = st_valid_q;
    assign st_adr      = st_adr_q;
    assign st_dat      = st_dat_q;
    assign st_sel      = st_sel_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_amber_wb_stim_ctrl.sv
// Directed bench for amber_wb_stim_ctrl: the bench plays the core on the wishbone side
// and the instruction source on the queue side, checking against hand-computed values.
module tb_amber_wb_stim_ctrl;
    import amber_stim_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [31:0] FILL  = 32'hF0801003;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic [3:0]  wait_states;
    logic        err_inject;
    logic        st_valid;
    logic [31:0] st_adr;
    logic [31:0] st_dat;
    logic [3:0]  st_sel;
    logic [15:0] fetch_count;
    logic [3:0]  q_level;

    int checks = 0;
    int errors = 0;
    int exp_fetch = 0;

    amber_wb_stim_ctrl_if wb ();

    amber_wb_stim_ctrl #(.DEPTH(DEPTH), .FILL_WORD(FILL)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_ready  (inst_ready),
        .wait_states (wait_states),
        .err_inject  (err_inject),
        .wb          (wb),
        .st_valid    (st_valid),
        .st_adr      (st_adr),
        .st_dat      (st_dat),
        .st_sel      (st_sel),
        .fetch_count (fetch_count),
        .q_level     (q_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        inst_valid = 1'b1;
        inst_data  = w;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat, output int lat, output logic ack,
                          output logic err, output logic [127:0] rdata, output logic stv,
                          output logic [31:0] sadr, output logic [31:0] sdat, output logic [3:0] ssel);
        wb.wb_we = we; wb.wb_adr = adr; wb.wb_sel = sel; wb.wb_dat_w = dat;
        wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        lat = -1; ack = 1'b0; err = 1'b0; rdata = '0; stv = 1'b0; sadr = '0; sdat = '0; ssel = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (wb.wb_ack || wb.wb_err) begin
                lat = i; ack = wb.wb_ack; err = wb.wb_err; rdata = wb.wb_dat_r;
                stv = st_valid; sadr = st_adr; sdat = st_dat; ssel = st_sel;
                break;
            end
        end
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
        step();
    endtask

    task automatic rd(input logic [31:0] adr, output int lat, output logic ack,
                      output logic err, output logic [127:0] rdata);
        logic        stv;
        logic [31:0] sadr, sdat;
        logic [3:0]  ssel;
        wb_txn(1'b0, adr, 16'hFFFF, '0, lat, ack, err, rdata, stv, sadr, sdat, ssel);
    endtask

    function automatic logic [127:0] exp_rd(input logic [1:0] lane, input logic [31:0] w);
        logic [127:0] r;
        r = {4{FILL}};
        r[lane*32 +: 32] = w;
        return r;
    endfunction

    task automatic test_reset();
        checks++; if (wb.wb_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0", wb.wb_ack); end
        checks++; if (wb.wb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", wb.wb_err); end
        checks++; if (wb.wb_dat_r !== {4{32'hF0801003}}) begin errors++; $display("[TB] FAIL reset_dat_r: got %h want %h", wb.wb_dat_r, {4{32'hF0801003}}); end
        checks++; if ({st_valid, st_adr, st_dat, st_sel} !== 69'd0) begin errors++; $display("[TB] FAIL reset_store: got %b/%h/%h/%h want zeros", st_valid, st_adr, st_dat, st_sel); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_fetch: got %0d want 0", fetch_count); end
        checks++; if (q_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", q_level); end
        checks++; if (inst_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", inst_ready); end
    endtask

    task automatic test_read_head();
        int lat; logic ack, err; logic [127:0] rdata;
        push_word(32'hE0811002);
        checks++; if (q_level !== 4'd1) begin errors++; $display("[TB] FAIL head_level_push: got %0d want 1", q_level); end
        rd(32'h0, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL head_latency: got %0d want 1", lat); end
        checks++; if (rdata !== {32'hF0801003, 32'hF0801003, 32'hF0801003, 32'hE0811002}) begin errors++; $display("[TB] FAIL head_data: got %h", rdata); end
        checks++; if (fetch_count !== 16'd1) begin errors++; $display("[TB] FAIL head_fetch: got %0d want 1", fetch_count); end
        checks++; if (q_level !== 4'd0) begin errors++; $display("[TB] FAIL head_level_pop: got %0d want 0", q_level); end
    endtask

    task automatic test_empty_read();
        int lat; logic ack, err; logic [127:0] rdata;
        rd(32'h8, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (lat !== 1 || ack !== 1'b1) begin errors++; $display("[TB] FAIL empty_ack: got lat %0d ack %b want 1/1", lat, ack); end
        checks++; if (rdata !== {4{32'hF0801003}}) begin errors++; $display("[TB] FAIL empty_data: got %h", rdata); end
        checks++; if (q_level !== 4'd0) begin errors++; $display("[TB] FAIL empty_level: got %0d want 0", q_level); end
    endtask

    task automatic test_wait_states();
        int lat; logic ack, err; logic [127:0] rdata;
        logic [3:0] ack_trace;
        push_word(32'h11112222);
        wait_states = 4'd3;
        wb.wb_we = 1'b0; wb.wb_adr = 32'h4; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) wait_states = 4'd0;
            ack_trace[i] = wb.wb_ack;
            if (i == 3) rdata = wb.wb_dat_r;
        end
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        step();
        exp_fetch++;
        checks++; if (ack_trace !== 4'b1000) begin errors++; $display("[TB] FAIL wait_latency: ack trace N+1..N+4 got %b want 1000", ack_trace); end
        checks++; if (rdata !== exp_rd(2'd1, 32'h11112222)) begin errors++; $display("[TB] FAIL wait_data: got %h", rdata); end
        // Abort: stb dropped at N+2 of a W=3 request must give no response and no pop.
        push_word(32'h33334444);
        wait_states = 4'd3;
        wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_adr = 32'h0;
        step();
        step();
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        wait_states = 4'd0;
        ack_trace = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_trace[i] = wb.wb_ack | wb.wb_err;
        end
        checks++; if (ack_trace !== 4'b0000) begin errors++; $display("[TB] FAIL abort_no_ack: got %b want 0000", ack_trace); end
        checks++; if (q_level !== 4'd1) begin errors++; $display("[TB] FAIL abort_level: got %0d want 1", q_level); end
        checks++; if (fetch_count !== 16'(exp_fetch)) begin errors++; $display("[TB] FAIL abort_fetch: got %0d want %0d", fetch_count, exp_fetch); end
        rd(32'h0, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (rdata !== exp_rd(2'd0, 32'h33334444)) begin errors++; $display("[TB] FAIL abort_drain: got %h", rdata); end
    endtask

    task automatic test_full();
        int lat; logic ack, err; logic [127:0] rdata;
        for (int i = 0; i < 8; i++) push_word(32'h10000000 + i);
        checks++; if (inst_ready !== 1'b0 || q_level !== 4'd8) begin errors++; $display("[TB] FAIL full_flag: got ready %b level %0d want 0/8", inst_ready, q_level); end
        push_word(32'h0BAD0BAD);
        checks++; if (q_level !== 4'd8) begin errors++; $display("[TB] FAIL full_ninth_push: got level %0d want 8", q_level); end
        // Pop while a push is offered: the push must still be refused during the full cycle.
        wb.wb_we = 1'b0; wb.wb_adr = 32'h0; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        inst_valid = 1'b1; inst_data = 32'h0BAD0BAD;
        step();
        ack = wb.wb_ack; rdata = wb.wb_dat_r;
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; inst_valid = 1'b0;
        step();
        exp_fetch++;
        checks++; if (ack !== 1'b1 || rdata !== exp_rd(2'd0, 32'h10000000)) begin errors++; $display("[TB] FAIL full_pop_data: ack %b data %h", ack, rdata); end
        checks++; if (q_level !== 4'd7) begin errors++; $display("[TB] FAIL full_pop_push: got level %0d want 7", q_level); end
        for (int i = 1; i < 8; i++) begin
            rd(32'(i * 4), lat, ack, err, rdata);
            exp_fetch++;
            checks++;
            if (rdata !== exp_rd(2'(i % 4), 32'h10000000 + i)) begin
                errors++; $display("[TB] FAIL full_order_%0d: got %h want %h", i, rdata, exp_rd(2'(i % 4), 32'h10000000 + i));
            end
        end
        rd(32'hC, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (rdata !== {4{32'hF0801003}}) begin errors++; $display("[TB] FAIL full_drained: got %h", rdata); end
        checks++; if (fetch_count !== 16'(exp_fetch)) begin errors++; $display("[TB] FAIL full_fetch: got %0d want %0d", fetch_count, exp_fetch); end
    endtask

    task automatic test_empty_push_same();
        int lat; logic ack, err; logic [127:0] rdata;
        wb.wb_we = 1'b0; wb.wb_adr = 32'h0; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        inst_valid = 1'b1; inst_data = 32'h5555AAAA;
        step();
        inst_valid = 1'b0;
        rdata = wb.wb_dat_r;
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        step();
        exp_fetch++;
        checks++; if (rdata !== {4{32'hF0801003}}) begin errors++; $display("[TB] FAIL emptypush_data: got %h", rdata); end
        checks++; if (q_level !== 4'd1) begin errors++; $display("[TB] FAIL emptypush_level: got %0d want 1", q_level); end
        rd(32'h0, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (rdata !== exp_rd(2'd0, 32'h5555AAAA)) begin errors++; $display("[TB] FAIL emptypush_stored: got %h", rdata); end
    endtask

    task automatic test_error();
        int lat; logic ack, err; logic [127:0] rdata;
        push_word(32'hCAFE0001);
        err_inject = 1'b1; step();
        err_inject = 1'b1; step();
        err_inject = 1'b0;
        rd(32'h0, lat, ack, err, rdata);
        checks++; if (err !== 1'b1 || ack !== 1'b0 || lat !== 1) begin errors++; $display("[TB] FAIL err_response: got err %b ack %b lat %0d want 1/0/1", err, ack, lat); end
        checks++; if (q_level !== 4'd1 || fetch_count !== 16'(exp_fetch)) begin errors++; $display("[TB] FAIL err_side_effects: level %0d fetch %0d want 1/%0d", q_level, fetch_count, exp_fetch); end
        rd(32'h0, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (ack !== 1'b1 || err !== 1'b0 || rdata !== exp_rd(2'd0, 32'hCAFE0001)) begin errors++; $display("[TB] FAIL err_retry: ack %b err %b data %h", ack, err, rdata); end
        rd(32'h0, lat, ack, err, rdata);
        exp_fetch++;
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL err_disarmed: ack %b err %b want 1/0", ack, err); end
    endtask

    task automatic test_write();
        int lat; logic ack, err, stv; logic [127:0] rdata; logic [31:0] sadr, sdat; logic [3:0] ssel;
        wb_txn(1'b1, 32'h104, 16'h00F0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
               lat, ack, err, rdata, stv, sadr, sdat, ssel);
        checks++; if (ack !== 1'b1 || stv !== 1'b1) begin errors++; $display("[TB] FAIL write_ack: ack %b st_valid %b want 1/1", ack, stv); end
        checks++; if (sadr !== 32'h104 || sdat !== 32'hDEADBEEF || ssel !== 4'hF) begin errors++; $display("[TB] FAIL write_capture: adr %h dat %h sel %h", sadr, sdat, ssel); end
        checks++; if (st_valid !== 1'b0) begin errors++; $display("[TB] FAIL write_pulse: st_valid got %b want 0", st_valid); end
        checks++; if (fetch_count !== 16'(exp_fetch)) begin errors++; $display("[TB] FAIL write_fetch: got %0d want %0d", fetch_count, exp_fetch); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ack_trace;
        wb.wb_we = 1'b0; wb.wb_adr = 32'h0; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            ack_trace[i] = wb.wb_ack;
        end
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        step();
        exp_fetch += 2;
        checks++; if (ack_trace !== 3'b101) begin errors++; $display("[TB] FAIL b2b_spacing: got %b want 101", ack_trace); end
        checks++; if (fetch_count !== 16'(exp_fetch)) begin errors++; $display("[TB] FAIL b2b_fetch: got %0d want %0d", fetch_count, exp_fetch); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        push_word(32'h77770000);
        wait_states = 4'd5;
        wb.wb_we = 1'b0; wb.wb_adr = 32'h0; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
        step();
        step();
        rst = 1'b1;
        #2;
        checks++; if (q_level !== 4'd0 || wb.wb_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flush: level %0d ack %b want 0/0", q_level, wb.wb_ack); end
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        step();
        rst = 1'b0;
        wait_states = 4'd0;
        exp_fetch = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | wb.wb_ack | wb.wb_err;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_ack: got ack seen %b want 0", seen); end
        checks++; if (fetch_count !== 16'd0 || q_level !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_state: fetch %0d level %0d want 0/0", fetch_count, q_level); end
    endtask

    initial begin
        rst = 1'b1;
        inst_valid = 1'b0; inst_data = '0; wait_states = 4'd0; err_inject = 1'b0;
        wb.wb_adr = '0; wb.wb_sel = '0; wb.wb_we = 1'b0; wb.wb_dat_w = '0;
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        test_reset();
        test_read_head();
        test_empty_read();
        test_wait_states();
        test_full();
        test_empty_push_same();
        test_error();
        test_write();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
